// File: rtl/conv_pkg.sv
// Shared types, widths and default generators for the convolutional encoder.
package conv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StTail,
    StDone
  } state_e;

  localparam int unsigned SYM_W = 2;
  localparam int unsigned LEN_W = 8;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned MAX_K = 7;

  // Default generator pairs per constraint length; bit 0 taps the current input.
  localparam logic [2:0] G0_K3 = 3'b111;
  localparam logic [2:0] G1_K3 = 3'b101;
  localparam logic [3:0] G0_K4 = 4'b1111;
  localparam logic [3:0] G1_K4 = 4'b1101;
  localparam logic [4:0] G0_K5 = 5'b11111;
  localparam logic [4:0] G1_K5 = 5'b11011;

  function automatic logic parity(input logic [MAX_K-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Encoder shift register and combinational symbol for the bit currently presented.
module conv_enc_core
  import conv_pkg::*;
#(
  parameter int unsigned   K  = 3,
  parameter logic [K-1:0]  G0 = 3'b111,
  parameter logic [K-1:0]  G1 = 3'b101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             bit_in,
  output logic [SYM_W-1:0] sym
);

  logic [K-2:0] st_q, st_d;
  logic [K-1:0] r;

  // Symbol for the register contents extended by the incoming bit.
  always_comb begin
    r   = {st_q, bit_in};
    sym = {parity(MAX_K'(r & G0)), parity(MAX_K'(r & G1))};
  end

  // Newest bit enters at the LSB; clear wins over load.
  always_comb begin
    st_d = st_q;
    if (clear) begin
      st_d = '0;
    end else if (load) begin
      st_d = {st_q[K-3:0], bit_in};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

endmodule

// File: rtl/conv_encoder_stream.sv
// Streaming rate-1/2 convolutional encoder with optional zero-tail termination.
module conv_encoder_stream
  import conv_pkg::*;
#(
  parameter int unsigned  K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             tail_en,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             sym_valid,
  output logic [SYM_W-1:0] sym,
  input  logic             sym_ready,
  output logic             sym_last,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sym_count
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               tail_q, tail_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               sym_valid_q, sym_valid_d;
  logic               sym_last_q, sym_last_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   sym_count_q, sym_count_d;

  logic               adv, accept, last_bit, last_tail;
  logic               core_clear, core_load, core_bit;
  logic [SYM_W-1:0]   core_sym;

  conv_enc_core #(
    .K (K),
    .G0(G0),
    .G1(G1)
  ) u_core (
    .clk   (clk),
    .rst   (rst),
    .clear (core_clear),
    .load  (core_load),
    .bit_in(core_bit),
    .sym   (core_sym)
  );

  // Handshake qualifiers; the output register may reload in the cycle it drains.
  always_comb begin
    adv       = !sym_valid_q || sym_ready;
    accept    = sym_valid_q && sym_ready;
    in_ready  = (state_q == StData) && adv;
    core_bit  = (state_q == StData) ? in_bit : 1'b0;
    last_bit  = (cnt_q == len_q - LEN_W'(1));
    last_tail = (cnt_q == LEN_W'(K - 2));
  end

  // FSM next state, counters and output register loading.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    tail_d      = tail_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    sym_count_d = sym_count_q;
    done_d      = 1'b0;
    core_clear  = 1'b0;
    core_load   = 1'b0;

    if (accept) begin
      sym_valid_d = 1'b0;
      sym_last_d  = 1'b0;
      if (sym_count_q != '1) begin
        sym_count_d = sym_count_q + CNT_W'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          core_clear  = 1'b1;
          cnt_d       = '0;
          len_d       = frame_len;
          tail_d      = tail_en;
          sym_count_d = '0;
          if (frame_len != '0) begin
            state_d = StData;
          end else if (tail_en) begin
            state_d = StTail;
          end else begin
            state_d = StDone;
          end
        end
      end
      StData: begin
        if (in_valid && in_ready) begin
          core_load   = 1'b1;
          sym_d       = core_sym;
          sym_valid_d = 1'b1;
          sym_last_d  = last_bit && !tail_q;
          if (last_bit) begin
            cnt_d   = '0;
            state_d = tail_q ? StTail : StDone;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      StTail: begin
        if (adv) begin
          core_load   = 1'b1;
          sym_d       = core_sym;
          sym_valid_d = 1'b1;
          sym_last_d  = last_tail;
          if (last_tail) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      StDone: begin
        // Empty register covers the zero-symbol frame.
        if (!sym_valid_q || accept) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      len_q       <= '0;
      tail_q      <= 1'b0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      done_q      <= 1'b0;
      sym_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      tail_q      <= tail_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      done_q      <= done_d;
      sym_count_q <= sym_count_d;
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym       = sym_q;
  assign sym_last  = sym_last_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Self-checking bench for conv_encoder_stream: K=3 frame table plus K=4/K=5 long frames.
module tb_conv_encoder_stream;
  import conv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, tail_en, in_valid, in_bit, sym_ready;
  logic [7:0] frame_len;
  logic       in_ready, sym_valid, sym_last, busy, done;
  logic [1:0] sym;
  logic [8:0] sym_count;

  logic       start2, in_valid2, in_bit2;
  logic       in_ready4, sym_valid4, sym_last4, busy4, done4;
  logic       in_ready5, sym_valid5, sym_last5, busy5, done5;
  logic [1:0] sym4, sym5;
  logic [8:0] cnt4, cnt5;

  conv_encoder_stream #(.K(3), .G0(G0_K3), .G1(G1_K3)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .tail_en(tail_en),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready), .sym_valid(sym_valid),
    .sym(sym), .sym_ready(sym_ready), .sym_last(sym_last), .busy(busy), .done(done),
    .sym_count(sym_count)
  );

  conv_encoder_stream #(.K(4), .G0(G0_K4), .G1(G1_K4)) dut4 (
    .clk(clk), .rst(rst), .start(start2), .frame_len(8'd64), .tail_en(1'b1),
    .in_valid(in_valid2), .in_bit(in_bit2), .in_ready(in_ready4), .sym_valid(sym_valid4),
    .sym(sym4), .sym_ready(1'b1), .sym_last(sym_last4), .busy(busy4), .done(done4),
    .sym_count(cnt4)
  );

  conv_encoder_stream #(.K(5), .G0(G0_K5), .G1(G1_K5)) dut5 (
    .clk(clk), .rst(rst), .start(start2), .frame_len(8'd64), .tail_en(1'b1),
    .in_valid(in_valid2), .in_bit(in_bit2), .in_ready(in_ready5), .sym_valid(sym_valid5),
    .sym(sym5), .sym_ready(1'b1), .sym_last(sym_last5), .busy(busy5), .done(done5),
    .sym_count(cnt5)
  );

  typedef struct packed {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  typedef struct {
    logic [7:0]  len;
    logic        tail;
    logic [7:0]  data;     // data[0] is sent first
    bit          rnd;      // random in_valid gaps and sym_ready
    logic [19:0] exp_syms; // symbol j at [2j+1:2j]
    int          exp_cnt;
  } vec_t;

  vec_t vecs[5];
  exp_t q3[$], q4[$], q5[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int n_acc3 = 0;
  int last_hs_cyc = 0;
  bit rand_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [1:0] ref_sym(input int g0, input int g1, input int st,
                                         input logic b);
    int r;
    r = (st << 1) | int'(b);
    return {^(r & g0), ^(r & g1)};
  endfunction

  task automatic cyc_counter();
    forever begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic drv_ready();
    forever begin
      @(posedge clk);
      #1;
      sym_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // Pops the expected symbol at each handshake; checks hold-while-stalled.
  task automatic mon3();
    logic [1:0] hs;
    logic       hl;
    bit         stalled;
    exp_t       e;
    stalled = 1'b0;
    hs = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk("stall_valid", 32'(sym_valid), 32'd1);
          chk("stall_sym", 32'(sym), 32'(hs));
          chk("stall_last", 32'(sym_last), 32'(hl));
        end
        if (sym_valid && !sym_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (sym_valid && sym_ready) begin
          if (q3.size() == 0) begin
            chk("unexpected_sym", 32'd1, 32'd0);
          end else begin
            e = q3.pop_front();
            chk("sym", 32'(sym), 32'(e.sym));
            chk("sym_last", 32'(sym_last), 32'(e.last));
          end
          n_acc3++;
          if (sym_last) last_hs_cyc = cyc;
        end
        stalled = sym_valid && !sym_ready;
        hs = sym;
        hl = sym_last;
      end
    end
  endtask

  task automatic mon45();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sym_valid4) begin
          if (q4.size() == 0) chk("k4_unexpected_sym", 32'd1, 32'd0);
          else begin
            e = q4.pop_front();
            chk("k4_sym", 32'(sym4), 32'(e.sym));
            chk("k4_last", 32'(sym_last4), 32'(e.last));
          end
        end
        if (sym_valid5) begin
          if (q5.size() == 0) chk("k5_unexpected_sym", 32'd1, 32'd0);
          else begin
            e = q5.pop_front();
            chk("k5_sym", 32'(sym5), 32'(e.sym));
            chk("k5_last", 32'(sym_last5), 32'(e.last));
          end
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_sym_valid"}, 32'(sym_valid), 32'd0);
    chk({tag, "_sym"}, 32'(sym), 32'd0);
    chk({tag, "_sym_last"}, 32'(sym_last), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_sym_count"}, 32'(sym_count), 32'd0);
  endtask

  // Runs one K=3 frame; stop_after>0 resets the DUT after that many accepted symbols.
  task automatic run_frame(input vec_t v, input int stop_after);
    int   i, guard, base, start_cyc, done_cyc;
    exp_t e;
    for (int j = 0; j < v.exp_cnt; j++) begin
      e.sym  = v.exp_syms[2*j +: 2];
      e.last = (j == v.exp_cnt - 1);
      q3.push_back(e);
    end
    rand_mode = v.rnd;
    base = n_acc3;
    @(posedge clk);
    #1;
    frame_len = v.len;
    tail_en   = v.tail;
    start     = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
    i = 0;
    guard = 0;
    while (i < int'(v.len) && guard < 1000) begin
      if (stop_after > 0 && n_acc3 - base >= stop_after) break;
      in_valid = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_bit   = v.data[i];
      @(negedge clk);
      if (in_valid && in_ready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (stop_after > 0) begin
      chk("rst_point_acc", 32'(n_acc3 - base), 32'(stop_after));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      q3.delete();
      rand_mode = 1'b0;
      return;
    end
    chk("data_accepted", 32'(i), 32'(v.len));
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (done !== 1'b1 && guard < 300);
    done_cyc = cyc;
    chk("done_seen", 32'(done), 32'd1);
    chk("sym_count", 32'(sym_count), 32'(v.exp_cnt));
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("all_syms_out", 32'(q3.size()), 32'd0);
    if (v.exp_cnt > 0) chk("done_after_last", 32'(done_cyc), 32'(last_hs_cyc + 1));
    else chk("done_after_start", 32'(done_cyc), 32'(start_cyc + 2));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    rand_mode = 1'b0;
  endtask

  task automatic run_k45();
    logic [7:0] pat;
    int         st4, st5, i, guard;
    exp_t       e;
    pat = 8'b1011_0100;
    st4 = 0;
    st5 = 0;
    for (int j = 0; j < 64 + 4; j++) begin
      logic b;
      b = (j < 64) ? pat[j % 8] : 1'b0;
      if (j < 64 + 3) begin
        e.sym  = ref_sym(int'(G0_K4), int'(G1_K4), st4, b);
        e.last = (j == 64 + 2);
        q4.push_back(e);
        st4 = ((st4 << 1) | int'(b)) & 7;
      end
      e.sym  = ref_sym(int'(G0_K5), int'(G1_K5), st5, b);
      e.last = (j == 64 + 3);
      q5.push_back(e);
      st5 = ((st5 << 1) | int'(b)) & 15;
    end
    @(posedge clk);
    #1;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    i = 0;
    guard = 0;
    while (i < 64 && guard < 500) begin
      in_valid2 = 1'b1;
      in_bit2   = pat[i % 8];
      @(negedge clk);
      chk("k45_in_ready", 32'({in_ready4, in_ready5}), 32'd3);
      if (in_ready4) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid2 = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (done5 !== 1'b1 && guard < 300);
    chk("k5_done", 32'(done5), 32'd1);
    chk("k5_count", 32'(cnt5), 32'd68);
    chk("k4_count", 32'(cnt4), 32'd67);
    chk("k4_all_out", 32'(q4.size()), 32'd0);
    chk("k5_all_out", 32'(q5.size()), 32'd0);
  endtask

  initial begin
    vecs[0] = '{len: 8'd8, tail: 1'b1, data: 8'b1011_0100, rnd: 1'b0,
                exp_syms: 20'b11_10_00_01_01_00_10_11_00_00, exp_cnt: 10};
    vecs[1] = '{len: 8'd8, tail: 1'b0, data: 8'b1011_0100, rnd: 1'b0,
                exp_syms: 20'b00_00_00_01_01_00_10_11_00_00, exp_cnt: 8};
    vecs[2] = '{len: 8'd8, tail: 1'b1, data: 8'b1011_0100, rnd: 1'b1,
                exp_syms: 20'b11_10_00_01_01_00_10_11_00_00, exp_cnt: 10};
    vecs[3] = '{len: 8'd0, tail: 1'b1, data: 8'h00, rnd: 1'b0,
                exp_syms: 20'b0, exp_cnt: 2};
    vecs[4] = '{len: 8'd0, tail: 1'b0, data: 8'h00, rnd: 1'b0,
                exp_syms: 20'b0, exp_cnt: 0};

    rst = 1'b1;
    start = 1'b0;
    frame_len = '0;
    tail_en = 1'b0;
    in_valid = 1'b0;
    in_bit = 1'b0;
    sym_ready = 1'b1;
    start2 = 1'b0;
    in_valid2 = 1'b0;
    in_bit2 = 1'b0;

    fork
      cyc_counter();
      drv_ready();
      mon3();
      mon45();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int t = 0; t < 5; t++) run_frame(vecs[t], 0);

    // Reset after three symbols, then the same frame must replay from st=0.
    run_frame(vecs[0], 3);
    run_frame(vecs[0], 0);

    // Start while busy must be ignored: second start mid-frame with a different length.
    fork
      run_frame(vecs[1], 0);
      begin
        repeat (4) @(posedge clk);
        #2;
        frame_len = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
      end
    join

    run_k45();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
